// File: rtl/cam_frame_writer.sv
// OV7670 capture into a framebuffer: synchronizes the camera bus onto clk, assembles
// RGB444 or luma pixels, clips them to the image window and issues single-cycle writes.
module cam_frame_writer #(
   parameter int unsigned c_img_cols    = 160,
   parameter int unsigned c_img_rows    = 120,
   parameter int unsigned c_nb_img_pxls = 15,
   parameter int unsigned c_nb_buf      = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ov7670_pclk,
   input  logic                     ov7670_vsync,
   input  logic                     ov7670_href,
   input  logic [7:0]               ov7670_d,
   input  logic                     rgbmode,
   input  logic                     testmode,
   output logic                     frame_we,
   output logic [c_nb_img_pxls-1:0] frame_addr,
   output logic [c_nb_buf-1:0]      frame_pixel,
   output logic                     frame_done,
   output logic                     capturing
);

   localparam logic [1:0] StWaitVs    = 2'd0;
   localparam logic [1:0] StWaitFrame = 2'd1;
   localparam logic [1:0] StActive    = 2'd2;

   localparam logic [7:0] ColLimit = 8'(c_img_cols);
   localparam logic [6:0] RowLimit = 7'(c_img_rows);

   // Two-stage synchronizers; *_prev_q hold the previous stage-2 value for edge detection.
   logic       pclk_s1_q, pclk_s2_q, pclk_prev_q;
   logic       href_s1_q, href_s2_q, href_prev_q;
   logic       vsync_s1_q, vsync_s2_q;
   logic [7:0] d_s1_q, d_s2_q;

   logic [1:0]               state_q, state_d;
   logic [6:0]               row_q, row_d;
   logic [7:0]               col_q, col_d;
   logic                     phase_q, phase_d;
   logic [7:0]               byte0_q, byte0_d;
   logic                     mode_q, mode_d;
   logic                     we_q, we_d;
   logic                     done_q, done_d;
   logic [c_nb_img_pxls-1:0] addr_q, addr_d;
   logic [c_nb_buf-1:0]      pixel_q, pixel_d;

   logic        pclk_rise, href_fall;
   logic [11:0] cam_pixel, test_pixel;

   assign pclk_rise = pclk_s2_q & ~pclk_prev_q;
   assign href_fall = href_prev_q & ~href_s2_q;

   assign cam_pixel  = mode_q ? {byte0_q[3:0], d_s2_q} : {4'h0, byte0_q};
   assign test_pixel = {{4{col_q[7]}}, {4{col_q[6]}}, {4{col_q[5]}}};

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      phase_d = phase_q;
      byte0_d = byte0_q;
      mode_d  = mode_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      pixel_d = pixel_q;
      addr_d  = we_q ? addr_q + 1'b1 : addr_q;

      unique case (state_q)
         StWaitVs: begin
            if (vsync_s2_q) state_d = StWaitFrame;
         end
         StWaitFrame: begin
            if (!vsync_s2_q) begin
               row_d   = '0;
               col_d   = '0;
               phase_d = 1'b0;
               addr_d  = '0;
               mode_d  = rgbmode;
               state_d = StActive;
            end
         end
         StActive: begin
            // vsync wins over any line or byte event in the same cycle
            if (vsync_s2_q) begin
               done_d  = 1'b1;
               state_d = StWaitFrame;
            end else if (href_fall) begin
               if (row_q != 7'h7F) row_d = row_q + 7'd1;
               col_d   = '0;
               phase_d = 1'b0;
            end else if (pclk_rise && href_s2_q) begin
               if (!phase_q) begin
                  byte0_d = d_s2_q;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (col_q != 8'hFF) col_d = col_q + 8'd1;
                  if (col_q < ColLimit && row_q < RowLimit) begin
                     we_d    = 1'b1;
                     pixel_d = c_nb_buf'(testmode ? test_pixel : cam_pixel);
                  end
               end
            end
         end
         default: state_d = StWaitVs;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pclk_s1_q   <= 1'b0;
         pclk_s2_q   <= 1'b0;
         pclk_prev_q <= 1'b0;
         href_s1_q   <= 1'b0;
         href_s2_q   <= 1'b0;
         href_prev_q <= 1'b0;
         vsync_s1_q  <= 1'b0;
         vsync_s2_q  <= 1'b0;
         d_s1_q      <= '0;
         d_s2_q      <= '0;
         state_q     <= StWaitVs;
         row_q       <= '0;
         col_q       <= '0;
         phase_q     <= 1'b0;
         byte0_q     <= '0;
         mode_q      <= 1'b0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         addr_q      <= '0;
         pixel_q     <= '0;
      end else begin
         pclk_s1_q   <= ov7670_pclk;
         pclk_s2_q   <= pclk_s1_q;
         pclk_prev_q <= pclk_s2_q;
         href_s1_q   <= ov7670_href;
         href_s2_q   <= href_s1_q;
         href_prev_q <= href_s2_q;
         vsync_s1_q  <= ov7670_vsync;
         vsync_s2_q  <= vsync_s1_q;
         d_s1_q      <= ov7670_d;
         d_s2_q      <= d_s1_q;
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         phase_q     <= phase_d;
         byte0_q     <= byte0_d;
         mode_q      <= mode_d;
         we_q        <= we_d;
         done_q      <= done_d;
         addr_q      <= addr_d;
         pixel_q     <= pixel_d;
      end
   end

   assign frame_we    = we_q;
   assign frame_done  = done_q;
   assign frame_addr  = addr_q;
   assign frame_pixel = pixel_q;
   assign capturing   = (state_q == StActive);

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomized bench for cam_frame_writer: a pixel-list model predicts every framebuffer write.
module tb_cam_frame_writer;

   localparam int unsigned Cols = 160;
   localparam int unsigned Rows = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ov7670_pclk, ov7670_vsync, ov7670_href;
   logic [7:0]  ov7670_d;
   logic        rgbmode, testmode;
   logic        frame_we, frame_done, capturing;
   logic [14:0] frame_addr;
   logic [11:0] frame_pixel;

   always #5 clk = ~clk;

   cam_frame_writer #(
      .c_img_cols   (Cols),
      .c_img_rows   (Rows),
      .c_nb_img_pxls(15),
      .c_nb_buf     (12)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ov7670_pclk (ov7670_pclk),
      .ov7670_vsync(ov7670_vsync),
      .ov7670_href (ov7670_href),
      .ov7670_d    (ov7670_d),
      .rgbmode     (rgbmode),
      .testmode    (testmode),
      .frame_we    (frame_we),
      .frame_addr  (frame_addr),
      .frame_pixel (frame_pixel),
      .frame_done  (frame_done),
      .capturing   (capturing)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   int exp_addr[$];
   int exp_pix[$];
   int exp_done   = 0;
   int seen_done  = 0;
   int wr_count   = 0;
   int mrow       = 0;
   bit frame_mode = 1'b0;
   bit model_live = 1'b0;
   int mon_a, mon_p;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_we) begin
            check_eq("we_expected", 32'(exp_addr.size() != 0), 32'(frame_we));
            if (exp_addr.size() != 0) begin
               mon_a = exp_addr.pop_front();
               mon_p = exp_pix.pop_front();
               check_eq("addr", 32'(frame_addr), mon_a);
               check_eq("pixel", 32'(frame_pixel), mon_p);
            end
         end
         if (frame_done) seen_done++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      ov7670_pclk = 1'b0;
      ov7670_d    = b;
      tick(2);
      ov7670_pclk = 1'b1;
      tick(2);
   endtask

   function automatic int pattern(input int c);
      int cs;
      cs = (c > 255) ? 255 : c;
      return ((cs >> 7) & 1) * 'hF00 + ((cs >> 6) & 1) * 'h0F0 + ((cs >> 5) & 1) * 'h00F;
   endfunction

   function automatic int expected_pixel(input bit tm, input logic [7:0] b0,
                                         input logic [7:0] b1, input int c);
      if (tm) return pattern(c);
      if (frame_mode) return int'(b0[3:0]) * 256 + int'(b1);
      return int'(b0);
   endfunction

   // kind: 0 = fixed RGB bytes 0A/BC, 1 = fixed YUV bytes 5A/33, 2 = random bytes
   task automatic run_line(input int npx, input bit odd, input bit tm, input int kind);
      logic [7:0] b0, b1;
      testmode = tm;
      tick(4);
      ov7670_href = 1'b1;
      for (int c = 0; c < npx; c++) begin
         case (kind)
            0:       begin b0 = 8'h0A; b1 = 8'hBC; end
            1:       begin b0 = 8'h5A; b1 = 8'h33; end
            default: begin b0 = 8'($urandom); b1 = 8'($urandom); end
         endcase
         if (model_live && c < int'(Cols) && mrow < int'(Rows)) begin
            exp_addr.push_back(wr_count);
            exp_pix.push_back(expected_pixel(tm, b0, b1, c));
            wr_count++;
         end
         send_byte(b0);
         send_byte(b1);
      end
      if (odd) send_byte(8'($urandom));
      ov7670_pclk = 1'b0;
      tick(2);
      ov7670_href = 1'b0;
      tick(8);
      mrow++;
   endtask

   task automatic frame_start(input bit mode);
      ov7670_vsync = 1'b1;
      tick(10);
      rgbmode = mode;
      tick(2);
      ov7670_vsync = 1'b0;
      tick(10);
      frame_mode = mode;
      model_live = 1'b1;
      mrow       = 0;
      wr_count   = 0;
      check_eq("capturing_on", 32'(capturing), 1);
   endtask

   task automatic frame_end();
      tick(6);
      check_eq("queue_drained", exp_addr.size(), 0);
      ov7670_vsync = 1'b1;
      exp_done++;
      tick(10);
      check_eq("done_count", seen_done, exp_done);
      check_eq("final_addr", 32'(frame_addr), wr_count);
      check_eq("capturing_off", 32'(capturing), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_we"}, 32'(frame_we), 0);
      check_eq({tag, "_done"}, 32'(frame_done), 0);
      check_eq({tag, "_capturing"}, 32'(capturing), 0);
      check_eq({tag, "_addr"}, 32'(frame_addr), 0);
      check_eq({tag, "_pixel"}, 32'(frame_pixel), 0);
   endtask

   initial begin
      rst          = 1'b1;
      ov7670_pclk  = 1'b0;
      ov7670_vsync = 1'b0;
      ov7670_href  = 1'b0;
      ov7670_d     = 8'h00;
      rgbmode      = 1'b1;
      testmode     = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(4);

      // Full RGB frame with constant bytes
      frame_start(1'b1);
      for (int r = 0; r < int'(Rows); r++) run_line(Cols, 1'b0, 1'b0, 0);
      frame_end();

      // YUV luma capture
      frame_start(1'b0);
      for (int r = 0; r < int'(Rows); r++) run_line(Cols, 1'b0, 1'b0, 1);
      frame_end();

      // Oversize lines are clipped at the right edge
      frame_start(1'($urandom));
      for (int r = 0; r < int'(Rows); r++) run_line(170, 1'b0, 1'b0, 2);
      frame_end();

      // One extra line plus a dangling odd byte on every line
      frame_start(1'b1);
      for (int r = 0; r <= int'(Rows); r++) run_line(Cols, 1'b1, 1'b0, 2);
      frame_end();

      // Color-bar test pattern
      frame_start(1'b1);
      run_line(Cols, 1'b0, 1'b1, 2);
      frame_end();

      // Random lengths, odd bytes and testmode; rgbmode flips mid-frame
      frame_start(1'($urandom));
      for (int r = 0; r <= int'(Rows); r++) begin
         run_line(int'($urandom_range(150, 200)), 1'($urandom), 1'($urandom), 2);
         rgbmode = ~rgbmode;
      end
      frame_end();

      // Reset partway through a line abandons the frame
      frame_start(1'b1);
      run_line(Cols, 1'b0, 1'b0, 2);
      testmode    = 1'b0;
      ov7670_href = 1'b1;
      for (int c = 0; c < 40; c++) begin
         exp_addr.push_back(wr_count);
         exp_pix.push_back(int'(8'h12 & 8'h0F) * 256 + 'h34);
         wr_count++;
         send_byte(8'h12);
         send_byte(8'h34);
      end
      tick(6);
      check_eq("pre_reset_drained", exp_addr.size(), 0);
      rst = 1'b1;
      tick(2);
      check_reset_outputs("midreset");
      rst        = 1'b0;
      model_live = 1'b0;
      for (int c = 0; c < 40; c++) begin
         send_byte(8'($urandom));
         send_byte(8'($urandom));
      end
      ov7670_pclk = 1'b0;
      tick(2);
      ov7670_href = 1'b0;
      tick(8);
      run_line(Cols, 1'b0, 1'b0, 2);
      check_eq("no_capture_after_reset", 32'(capturing), 0);
      ov7670_vsync = 1'b1;
      tick(10);
      check_eq("no_done_after_reset", seen_done, exp_done);
      frame_start(1'b1);
      run_line(20, 1'b0, 1'b0, 2);
      frame_end();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cam_frame_writer.md
CAM_FRAME_WRITER -- requirements
Module: cam_frame_writer

Interface
REQ-001 Parameters (name, default, meaning):
- c_img_cols, 160, image columns.
- c_img_rows, 120, image rows.
- c_nb_img_pxls, 15, framebuffer address width.
- c_nb_buf, 12, framebuffer word width (RGB444).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, FPGA clock; one clock only.
- rst, in, 1, reset: synchronous, active-high.
- ov7670_pclk, in, 1, camera pixel clock, sampled as data.
- ov7670_vsync, in, 1, camera vertical sync, high = vertical blanking.
- ov7670_href, in, 1, camera line valid.
- ov7670_d, in, 8, camera data byte.
- rgbmode, in, 1, 1 = RGB444 capture, 0 = YUV422 luma capture.
- testmode, in, 1, 1 = write color-bar pattern instead of camera data.
- frame_we, out, 1, framebuffer write enable, one-clk pulse.
- frame_addr, out, c_nb_img_pxls, framebuffer write address.
- frame_pixel, out, c_nb_buf, framebuffer write data.
- frame_done, out, 1, one-clk pulse at end of a captured frame.
- capturing, out, 1, high while in state ACTIVE.

Function
REQ-003 Synchronization: ov7670_pclk, vsync, href and d SHALL pass through a 2-FF synchronizer on clk. A pclk rising edge is detected from synchronized pclk (previous 0, current 1). href and d SHALL be taken from the same synchronizer stage as that edge.
REQ-004 Clock ratio: clk frequency SHALL be at least 4x pclk frequency. No behaviour is guaranteed below that ratio.
REQ-005 States:
- WAIT_VS: wait for synchronized vsync = 1, then go to WAIT_FRAME.
- WAIT_FRAME: on vsync = 0, clear row, col, byte phase and frame_addr to 0; latch rgbmode into the frame mode register; go to ACTIVE.
- ACTIVE: capture. When vsync = 1: pulse frame_done for exactly one clk, go to WAIT_FRAME.
REQ-006 Byte capture (ACTIVE only): on each pclk edge with href = 1, phase 0 stores byte0 and sets phase to 1. Phase 1 assembles the pixel and clears phase to 0.
REQ-007 Pixel packing:
- Mode RGB: pixel = {byte0[3:0], byte1[7:0]}, i.e. R, G, B nibbles, bits 11:0.
- Mode YUV: pixel = {4'h0, byte0}; the Y byte sits in bits 7:0 and byte1 (U/V) is discarded.
REQ-008 Write: frame_we SHALL rise the clk cycle after the detected pclk edge that completes phase 1, provided col < c_img_cols and row < c_img_rows. frame_addr and frame_pixel SHALL be valid in that same cycle.
REQ-009 Address: frame_addr SHALL increment by 1 in the cycle after each write. Consecutive writes therefore form row*c_img_cols + col. Pixels with col >= c_img_cols or row >= c_img_rows SHALL not be written and SHALL not advance frame_addr.
REQ-010 Column counter: col SHALL increment after every completed pixel, whether written or not, and SHALL saturate at 2^8-1.
REQ-011 Line end: when synchronized href falls (1 to 0) in ACTIVE:
- row increments, saturating at 2^7-1;
- col clears to 0;
- phase clears to 0, discarding a pending odd byte0 without a write.
REQ-012 Test pattern: when testmode = 1, frame_pixel SHALL be {{4{col[7]}},{4{col[6]}},{4{col[5]}}}, replacing camera data. Timing, addressing and clipping are identical to camera capture.
REQ-013 Default outputs: frame_we and frame_done SHALL be 0 in every cycle not covered by REQ-008 and REQ-005. frame_pixel and frame_addr SHALL hold their values between writes.
REQ-014 Mid-line vsync: vsync = 1 mid-line SHALL take priority over href or byte events in the same cycle. In that case frame_done pulses and no write occurs.
REQ-015 Mid-frame mode change: rgbmode changes during ACTIVE SHALL take effect only at the next frame start. testmode takes effect per pixel.

Reset
REQ-016 With rst = 1 at a clk edge, the block SHALL:
- enter WAIT_VS;
- clear all counters, phase and synchronizer registers;
- drive frame_we = 0, frame_done = 0, capturing = 0, frame_addr = 0, frame_pixel = 0.
REQ-017 Reset mid-frame: a reset mid-frame SHALL abandon the frame without a frame_done pulse. Capture restarts only after a full vsync high-then-low sequence.

Verification
REQ-018 Full RGB frame: after reset, drive vsync 1 then 0, then 120 lines of 320 bytes, with byte0 = 8'h0A and byte1 = 8'hBC. Required: exactly 19200 frame_we pulses, frame_pixel = 12'hABC, frame_addr running 0..19199, then one frame_done when vsync rises.
REQ-019 YUV mode: rgbmode = 0, bytes Y = 8'h5A, U = 8'h33. Required: frame_pixel = 12'h05A; U byte never appears on frame_pixel.
REQ-020 Oversize line: 170-pixel lines (340 bytes). Required: 160 writes per line; frame_addr at the start of line 1 = 160; no write for col 160..169.
REQ-021 Odd byte and 121 lines: 121 lines, each ending with an odd extra byte. Required: no write for the dangling byte; no write on row 120; final frame_addr = 19200.
REQ-022 Test pattern: testmode = 1, one line. Required: col 0..31 write 12'h000, col 32..63 write 12'h00F, col 128..159 write 12'hF00.
REQ-023 Reset mid-frame: assert rst at pixel 5000, then deassert. Required: frame_we and frame_done stay 0 until a new vsync 1-then-0 sequence; the next frame starts at frame_addr 0.
